// File: rtl/lc3_console_pkg.sv
// lc3_console_pkg: shared constants and types for the LC-3 console device.
//   - Register byte offsets relative to BASE_ADDR (KBSR, KBDR, DSR, DDR).
//   - Status bit positions (ready bit, interrupt-enable bit).
//   - bus_word_t: the 16-bit CPU bus word.
//   - status_word(): builds a KBSR/DSR read value from its two live bits.
package lc3_console_pkg;

    typedef logic [15:0] bus_word_t;

    localparam bus_word_t KBSR_OFS = 16'h0000;
    localparam bus_word_t KBDR_OFS = 16'h0002;
    localparam bus_word_t DSR_OFS  = 16'h0004;
    localparam bus_word_t DDR_OFS  = 16'h0006;

    localparam int RDY_BIT = 15;
    localparam int IE_BIT  = 14;

    // Status registers expose only the ready and IE bits; all others read 0.
    function automatic bus_word_t status_word(input logic rdy, input logic ie);
        bus_word_t word;
        word          = 16'h0000;
        word[RDY_BIT] = rdy;
        word[IE_BIT]  = ie;
        return word;
    endfunction

endpackage

// File: rtl/lc3_sync_fifo.sv
// lc3_sync_fifo: single-clock FIFO with wrap-bit pointers.
//   clk, rst_n          : clock, synchronous active-low reset (empties FIFO)
//   push, push_data     : write request; ignored while full
//   pop                 : read request; ignored while empty
//   full, empty         : derived from the read/write pointer compare
//   head                : oldest entry (meaningful only while !empty)
module lc3_sync_fifo
    import lc3_console_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Same index with opposite wrap bits means the writer lapped the reader.
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update; push and pop may both land in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + PTR_INC;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
        end
    end

endmodule

// File: rtl/lc3_console_mmio.sv
// lc3_console_mmio: LC-3 keyboard/display console behind the memory bus.
//   Bus side : mem_en/mem_we/mem_addr/mem_wdata in; mem_rdata/mem_rvalid out
//              (registered, one-cycle read latency). Registers at BASE_ADDR:
//              KBSR(+0) KBDR(+2, read pops RX) DSR(+4) DDR(+6, write pushes TX).
//   Pad side : pad_kb_* valid/ready into the RX FIFO,
//              pad_disp_* valid/ready out of the TX FIFO.
//   IRQs     : kb_irq = RX not empty & KBSR.IE;
//              disp_irq = TX not full & DSR.IE when LC3_CONSOLE_DISP_IRQ_EN
//              is defined, otherwise tied low and DSR[14] reads 0.
module lc3_console_mmio
    import lc3_console_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          RX_DEPTH  = 4,
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] BASE_ADDR = 16'hFE00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    output logic              mem_rvalid,
    input  logic              pad_kb_valid,
    input  logic [DATA_W-1:0] pad_kb_data,
    output logic              pad_kb_ready,
    output logic              pad_disp_valid,
    output logic [DATA_W-1:0] pad_disp_data,
    input  logic              pad_disp_ready,
    output logic              kb_irq,
    output logic              disp_irq
);

    bus_word_t         ofs_s;
    logic              rd_s;
    logic              wr_s;
    logic              rx_full_s;
    logic              rx_empty_s;
    logic [DATA_W-1:0] rx_head_s;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic [DATA_W-1:0] tx_head_s;
    logic              rx_pop_s;
    logic              tx_push_s;
    logic              kb_ie_r;
    logic              disp_ie_s;
    bus_word_t         rdata_s;
    bus_word_t         mem_rdata_r;
    logic              mem_rvalid_r;
    logic              unused_s;

    // Offsets outside 0..7 simply fall into the default (read-0, write-ignored) decode.
    assign ofs_s     = mem_addr - BASE_ADDR;
    assign rd_s      = mem_en & ~mem_we;
    assign wr_s      = mem_en & mem_we;
    assign rx_pop_s  = rd_s & (ofs_s == KBDR_OFS);
    assign tx_push_s = wr_s & (ofs_s == DDR_OFS);
    assign unused_s  = ^mem_wdata;

    lc3_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pad_kb_valid),
        .push_data (pad_kb_data),
        .pop       (rx_pop_s),
        .full      (rx_full_s),
        .empty     (rx_empty_s),
        .head      (rx_head_s)
    );

    lc3_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push_s),
        .push_data (mem_wdata[DATA_W-1:0]),
        .pop       (pad_disp_ready),
        .full      (tx_full_s),
        .empty     (tx_empty_s),
        .head      (tx_head_s)
    );

    // Keyboard interrupt-enable bit, written through KBSR[14].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kb_ie_r <= 1'b0;
        end else if (wr_s && (ofs_s == KBSR_OFS)) begin
            kb_ie_r <= mem_wdata[IE_BIT];
        end else begin
            kb_ie_r <= kb_ie_r;
        end
    end

`ifdef LC3_CONSOLE_DISP_IRQ_EN
    logic disp_ie_r;

    // Display interrupt-enable bit, written through DSR[14].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_ie_r <= 1'b0;
        end else if (wr_s && (ofs_s == DSR_OFS)) begin
            disp_ie_r <= mem_wdata[IE_BIT];
        end else begin
            disp_ie_r <= disp_ie_r;
        end
    end

    assign disp_ie_s = disp_ie_r;
`else
    assign disp_ie_s = 1'b0;
`endif

    // Read mux over pre-edge state; an empty KBDR returns 0 rather than stale storage.
    always_comb begin
        rdata_s = 16'h0000;
        case (ofs_s)
            KBSR_OFS: rdata_s = status_word(~rx_empty_s, kb_ie_r);
            KBDR_OFS: begin
                if (!rx_empty_s) begin
                    rdata_s[DATA_W-1:0] = rx_head_s;
                end else begin
                    rdata_s = 16'h0000;
                end
            end
            DSR_OFS:  rdata_s = status_word(~tx_full_s, disp_ie_s);
            default:  rdata_s = 16'h0000;
        endcase
    end

    // Registered read port; data holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rdata_r  <= 16'h0000;
            mem_rvalid_r <= 1'b0;
        end else begin
            mem_rvalid_r <= rd_s;
            if (rd_s) begin
                mem_rdata_r <= rdata_s;
            end else begin
                mem_rdata_r <= mem_rdata_r;
            end
        end
    end

    assign mem_rdata      = mem_rdata_r;
    assign mem_rvalid     = mem_rvalid_r;
    assign pad_kb_ready   = ~rx_full_s;
    assign pad_disp_valid = ~tx_empty_s;
    assign pad_disp_data  = tx_head_s;
    assign kb_irq         = ~rx_empty_s & kb_ie_r;
    assign disp_irq       = ~tx_full_s & disp_ie_s;

endmodule

// File: tb/tb_lc3_console_mmio.sv
// Scoreboard bench for lc3_console_mmio: a queue-based model of the console
// advances on every rising edge; expected read words are queued and a negedge
// monitor pops them when mem_rvalid appears, and checks pad/IRQ outputs
// against the model's queues.
module tb_lc3_console_mmio;

    localparam int          DW   = 8;
    localparam int          RXD  = 4;
    localparam int          TXD  = 4;
    localparam logic [15:0] BASE = 16'hFE00;
    localparam logic [15:0] O_KBSR = 16'h0000;
    localparam logic [15:0] O_KBDR = 16'h0002;
    localparam logic [15:0] O_DSR  = 16'h0004;
    localparam logic [15:0] O_DDR  = 16'h0006;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_en = 1'b0;
    logic          mem_we = 1'b0;
    logic [15:0]   mem_addr = 16'h0000;
    logic [15:0]   mem_wdata = 16'h0000;
    logic [15:0]   mem_rdata;
    logic          mem_rvalid;
    logic          pad_kb_valid = 1'b0;
    logic [DW-1:0] pad_kb_data = 8'h00;
    logic          pad_kb_ready;
    logic          pad_disp_valid;
    logic [DW-1:0] pad_disp_data;
    logic          pad_disp_ready = 1'b0;
    logic          kb_irq;
    logic          disp_irq;

    lc3_console_mmio #(.DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .pad_kb_valid   (pad_kb_valid),
        .pad_kb_data    (pad_kb_data),
        .pad_kb_ready   (pad_kb_ready),
        .pad_disp_valid (pad_disp_valid),
        .pad_disp_data  (pad_disp_data),
        .pad_disp_ready (pad_disp_ready),
        .kb_irq         (kb_irq),
        .disp_irq       (disp_irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] tx_q[$];
    logic [15:0]   exp_rd_q[$];
    logic          kb_ie_m = 1'b0;
    logic          disp_ie_m = 1'b0;
    logic [15:0]   last_rdata_m = 16'h0000;
    logic          exp_rv_m = 1'b0;
    logic          chk_en = 1'b0;
    int            n_cmp = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs held during it.
    task automatic model_step();
        int          rxn;
        int          txn;
        logic [15:0] ofs;
        logic [15:0] rv;
        rxn = rx_q.size();
        txn = tx_q.size();
        ofs = mem_addr - BASE;
        if (!rst_n) begin
            rx_q.delete();
            tx_q.delete();
            exp_rd_q.delete();
            kb_ie_m      = 1'b0;
            disp_ie_m    = 1'b0;
            last_rdata_m = 16'h0000;
            exp_rv_m     = 1'b0;
            return;
        end
        exp_rv_m = 1'b0;
        if (mem_en && !mem_we) begin
            rv = 16'h0000;
            if (ofs == O_KBSR) rv = {rxn != 0, kb_ie_m, 14'd0};
            if (ofs == O_KBDR && rxn != 0) rv = {8'h00, rx_q[0]};
            if (ofs == O_DSR) rv = {txn < TXD, disp_ie_m, 14'd0};
            exp_rd_q.push_back(rv);
            last_rdata_m = rv;
            exp_rv_m     = 1'b1;
            if (ofs == O_KBDR && rxn != 0) void'(rx_q.pop_front());
        end
        if (pad_disp_ready && txn != 0) void'(tx_q.pop_front());
        if (mem_en && mem_we) begin
            if (ofs == O_KBSR) kb_ie_m = mem_wdata[14];
`ifdef LC3_CONSOLE_DISP_IRQ_EN
            if (ofs == O_DSR) disp_ie_m = mem_wdata[14];
`endif
            if (ofs == O_DDR && txn < TXD) tx_q.push_back(mem_wdata[7:0]);
        end
        if (pad_kb_valid && rxn < RXD) rx_q.push_back(pad_kb_data);
    endtask

    // Monitor: compare DUT outputs with the model between edges.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("kb_ready", 32'(pad_kb_ready), 32'(rx_q.size() < RXD));
            chk("disp_valid", 32'(pad_disp_valid), 32'(tx_q.size() != 0));
            chk("kb_irq", 32'(kb_irq), 32'(kb_ie_m && rx_q.size() != 0));
            chk("disp_irq", 32'(disp_irq), 32'(disp_ie_m && tx_q.size() < TXD));
            chk("rvalid", 32'(mem_rvalid), 32'(exp_rv_m));
            chk("rdata_hold", 32'(mem_rdata), 32'(last_rdata_m));
            if (pad_disp_valid && tx_q.size() != 0) begin
                chk("disp_data", 32'(pad_disp_data), 32'(tx_q[0]));
            end
            if (mem_rvalid) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'(mem_rdata), 32'hFFFF_FFFF);
                end else begin
                    chk("rd_data", 32'(mem_rdata), 32'(exp_rd_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_rd(input logic [15:0] ofs);
        mem_en = 1'b1; mem_we = 1'b0; mem_addr = BASE + ofs;
        tick();
        mem_en = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] ofs, input logic [15:0] d);
        mem_en = 1'b1; mem_we = 1'b1; mem_addr = BASE + ofs; mem_wdata = d;
        tick();
        mem_en = 1'b0; mem_we = 1'b0;
    endtask

    initial begin
        // Reset and status after reset
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        bus_rd(O_KBSR);
        bus_rd(O_DSR);
        tick();

        // One char with keyboard IE set, then consume it
        pad_kb_valid = 1'b1; pad_kb_data = 8'h41;
        tick();
        pad_kb_valid = 1'b0;
        bus_wr(O_KBSR, 16'h4000);
        tick();
        bus_rd(O_KBDR);
        bus_rd(O_KBSR);
        bus_wr(O_KBSR, 16'h0000);

        // Fill RX past depth, pop while the 5th char is still offered
        pad_kb_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            pad_kb_data = 8'(i);
            tick();
        end
        bus_rd(O_KBDR);
        tick();
        pad_kb_valid = 1'b0;
        for (int i = 0; i < 5; i++) bus_rd(O_KBDR);
        bus_rd(O_KBDR);
        bus_rd(O_KBSR);

        // Fill TX with display stalled, one write dropped, then drain
        pad_disp_ready = 1'b0;
        for (int i = 10; i <= 14; i++) bus_wr(O_DDR, 16'(i));
        bus_rd(O_DSR);
        pad_disp_ready = 1'b1;
        repeat (6) tick();
        bus_rd(O_DSR);

        // Display IE write (effective only with the optional feature)
        bus_wr(O_DSR, 16'h4000);
        bus_rd(O_DSR);
        bus_wr(O_DDR, 16'h0077);
        pad_disp_ready = 1'b0;
        bus_wr(O_DDR, 16'h0078);

        // Unmapped / out-of-window reads and writes
        bus_rd(O_DDR);
        bus_rd(16'h0001);
        bus_rd(16'h0010);
        bus_wr(16'h0003, 16'hFFFF);

        // Reset in the middle of traffic
        pad_kb_valid = 1'b1; pad_kb_data = 8'h55;
        bus_wr(O_KBSR, 16'h4000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pad_kb_valid = 1'b0;
        bus_rd(O_KBSR);
        bus_rd(O_DSR);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n          = ($urandom_range(0, 699) != 0);
            mem_en         = 1'($urandom_range(0, 1));
            mem_we         = 1'($urandom_range(0, 1));
            mem_addr       = BASE + 16'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) mem_addr = 16'($urandom);
            mem_wdata      = 16'($urandom);
            pad_kb_valid   = ($urandom_range(0, 2) == 0);
            pad_kb_data    = 8'($urandom);
            pad_disp_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst_n = 1'b1; mem_en = 1'b0; mem_we = 1'b0;
        pad_kb_valid = 1'b0; pad_disp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rdq_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
